chip_sched: RTL and testbench

Round-robin scan controller for the chip capture path. It drives the 8:1 sensor-path select and the capture threshold. It dwells on each enabled channel for a programmed number of sample strobes, waiting for a threshold capture to occur. If a capture fires, it holds the channel until the capture window closes, then waits a holdoff and advances. It sits between the config register block and the chip capture path, alongside the sm1..sm8 sample front-end.

---
 rtl/chip_sched.sv | 235 +++++++++++++++++++++++
 tb/tb_chip_sched.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chip_sched.sv
// rtl/chip_sched.sv - round-robin capture-path scan controller (optional CHIP_SCHED_TIMEOUT_EN: capture timeout)
module chip_sched #(
    parameter int SETTLE_SMP = 4,
    parameter int NCH        = 8
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        cfg_run,
    input  logic [7:0]  cfg_ch_mask,
    input  logic [15:0] cfg_dwell,
    input  logic [15:0] cfg_holdoff,
    input  logic [15:0] cfg_th,
`ifdef CHIP_SCHED_TIMEOUT_EN
    input  logic [19:0] cfg_cap_max,
    output logic        cap_to,
`endif
    input  logic        sm_vld,
    input  logic        buf_rdy,
    input  logic        cap_vld,
    output logic [7:0]  path_sel,
    output logic [15:0] chip_th,
    output logic        sched_busy,
    output logic        ch_done,
    output logic        ch_hit,
    output logic [15:0] evt_cnt,
    output logic        mask_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_SETTLE,
        S_DWELL,
        S_CAPTURE,
        S_HOLD
    } state_t;

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_SMP - 1);

    state_t      state_q, state_d;
    logic [2:0]  path_q, path_d;
    logic [15:0] th_q, th_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] evt_q, evt_d;
    logic        done_q, done_d;
    logic        hit_q, hit_d;
    logic        merr_q, merr_d;
`ifdef CHIP_SCHED_TIMEOUT_EN
    logic [19:0] ccnt_q, ccnt_d;
    logic        cto_q, cto_d;
`endif

    logic        tick;
    logic [15:0] dwell_eff;
    logic [2:0]  nxt_ch;
    logic [2:0]  idx;

    assign tick      = sm_vld & buf_rdy;
    assign dwell_eff = (cfg_dwell == 16'd0) ? 16'd1 : cfg_dwell;

    // Search downwards so the smallest forward distance wins; distance NCH reselects the current path.
    always_comb begin
        nxt_ch = path_q;
        idx    = path_q;
        for (int k = NCH; k >= 1; k--) begin
            idx = path_q + 3'(k);
            if (cfg_ch_mask[idx]) begin
                nxt_ch = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        path_d  = path_q;
        th_d    = th_q;
        cnt_d   = cnt_q;
        evt_d   = evt_q;
        done_d  = 1'b0;
        hit_d   = 1'b0;
        merr_d  = merr_q;
`ifdef CHIP_SCHED_TIMEOUT_EN
        ccnt_d  = ccnt_q;
        cto_d   = cto_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cfg_run) begin
                    if (cfg_ch_mask != 8'd0) begin
                        state_d = S_SEL;
                        evt_d   = 16'd0;
                        merr_d  = 1'b0;
`ifdef CHIP_SCHED_TIMEOUT_EN
                        cto_d   = 1'b0;
`endif
                    end else begin
                        merr_d = 1'b1;
                    end
                end
            end
            S_SEL: begin
                if (!cfg_run) begin
                    state_d = S_IDLE;
                end else if (cfg_ch_mask == 8'd0) begin
                    merr_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    path_d  = nxt_ch;
                    th_d    = cfg_th;
                    cnt_d   = 16'd0;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (!cfg_run) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_d   = 16'd0;
                        state_d = S_DWELL;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            S_DWELL: begin
                if (!cfg_run) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    if (cap_vld) begin
                        state_d = S_CAPTURE;
                        cnt_d   = 16'd0;
                        if (evt_q != 16'hFFFF) begin
                            evt_d = evt_q + 16'd1;
                        end
`ifdef CHIP_SCHED_TIMEOUT_EN
                        ccnt_d = 20'd0;
`endif
                    end else if (cnt_q >= dwell_eff - 16'd1) begin
                        done_d  = 1'b1;
                        state_d = S_SEL;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            S_CAPTURE: begin
                // A stop request lets the window finish, then skips the holdoff.
                if (tick) begin
                    if (!cap_vld) begin
                        cnt_d = 16'd0;
                        if (!cfg_run) begin
                            done_d  = 1'b1;
                            hit_d   = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_HOLD;
                        end
                    end
`ifdef CHIP_SCHED_TIMEOUT_EN
                    else if (cfg_cap_max != 20'd0) begin
                        if (ccnt_q >= cfg_cap_max - 20'd1) begin
                            cto_d   = 1'b1;
                            cnt_d   = 16'd0;
                            state_d = S_HOLD;
                        end else begin
                            ccnt_d = ccnt_q + 20'd1;
                        end
                    end
`endif
                end
            end
            S_HOLD: begin
                if (!cfg_run) begin
                    state_d = S_IDLE;
                end else if (cfg_holdoff == 16'd0) begin
                    done_d  = 1'b1;
                    hit_d   = 1'b1;
                    state_d = S_SEL;
                end else if (tick) begin
                    if (cnt_q >= cfg_holdoff - 16'd1) begin
                        done_d  = 1'b1;
                        hit_d   = 1'b1;
                        state_d = S_SEL;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            path_q  <= 3'd0;
            th_q    <= 16'd0;
            cnt_q   <= 16'd0;
            evt_q   <= 16'd0;
            done_q  <= 1'b0;
            hit_q   <= 1'b0;
            merr_q  <= 1'b0;
`ifdef CHIP_SCHED_TIMEOUT_EN
            ccnt_q  <= 20'd0;
            cto_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            path_q  <= path_d;
            th_q    <= th_d;
            cnt_q   <= cnt_d;
            evt_q   <= evt_d;
            done_q  <= done_d;
            hit_q   <= hit_d;
            merr_q  <= merr_d;
`ifdef CHIP_SCHED_TIMEOUT_EN
            ccnt_q  <= ccnt_d;
            cto_q   <= cto_d;
`endif
        end
    end

    assign path_sel   = {5'd0, path_q};
    assign chip_th    = th_q;
    assign sched_busy = (state_q != S_IDLE);
    assign ch_done    = done_q;
    assign ch_hit     = hit_q;
    assign evt_cnt    = evt_q;
    assign mask_err   = merr_q;
`ifdef CHIP_SCHED_TIMEOUT_EN
    assign cap_to     = cto_q;
`endif

endmodule

// File: tb/tb_chip_sched.sv
// tb/tb_chip_sched.sv - visit-level reference model bench for chip_sched
module tb_chip_sched;
    localparam int SETTLE = 4;

    logic        clk_sys = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_run = 1'b0;
    logic [7:0]  cfg_ch_mask = 8'd0;
    logic [15:0] cfg_dwell = 16'd0;
    logic [15:0] cfg_holdoff = 16'd0;
    logic [15:0] cfg_th = 16'd0;
    logic        sm_vld = 1'b0;
    logic        buf_rdy = 1'b0;
    logic        cap_vld = 1'b0;
    logic [7:0]  path_sel;
    logic [15:0] chip_th;
    logic        sched_busy;
    logic        ch_done;
    logic        ch_hit;
    logic [15:0] evt_cnt;
    logic        mask_err;
`ifdef CHIP_SCHED_TIMEOUT_EN
    logic [19:0] cfg_cap_max = 20'd0;
    logic        cap_to;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_done = -1;
    int exp_period = 0;
    bit cont = 1'b0;
    logic [2:0]  exp_ch = 3'd0;
    logic [15:0] exp_th = 16'd0;
    logic [15:0] exp_evt = 16'd0;

    chip_sched #(.SETTLE_SMP(SETTLE), .NCH(8)) dut (
        .clk_sys(clk_sys), .rst_n(rst_n), .cfg_run(cfg_run), .cfg_ch_mask(cfg_ch_mask),
        .cfg_dwell(cfg_dwell), .cfg_holdoff(cfg_holdoff), .cfg_th(cfg_th),
`ifdef CHIP_SCHED_TIMEOUT_EN
        .cfg_cap_max(cfg_cap_max), .cap_to(cap_to),
`endif
        .sm_vld(sm_vld), .buf_rdy(buf_rdy), .cap_vld(cap_vld),
        .path_sel(path_sel), .chip_th(chip_th), .sched_busy(sched_busy),
        .ch_done(ch_done), .ch_hit(ch_hit), .evt_cnt(evt_cnt), .mask_err(mask_err)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Next enabled channel strictly after cur, wrapping; a lone bit reselects itself.
    function automatic logic [2:0] next_ch(input logic [2:0] cur, input logic [7:0] m);
        for (int k = 1; k <= 8; k++) begin
            if (m[(int'(cur) + k) % 8]) return 3'((int'(cur) + k) % 8);
        end
        return cur;
    endfunction

    task automatic step(input logic sv, input logic br, input logic cv);
        sm_vld = sv;
        buf_rdy = br;
        cap_vld = cv;
        @(posedge clk_sys);
        @(negedge clk_sys);
    endtask

    task automatic rstep(input logic cv_tick, input logic cv_idle, output bit tk);
        logic sv, br;
        if (cont) begin
            sv = 1'b1;
            br = 1'b1;
        end else begin
            sv = ($urandom_range(0, 3) != 0);
            br = ($urandom_range(0, 3) != 0);
        end
        tk = sv & br;
        step(sv, br, tk ? cv_tick : cv_idle);
    endtask

    task automatic mid_chk(input string tag);
        chk({tag, "_done"}, 32'(ch_done), 0);
        chk({tag, "_busy"}, 32'(sched_busy), 1);
        chk({tag, "_path"}, 32'(path_sel), 32'(exp_ch));
    endtask

    task automatic done_chk(input string tag, input bit hit);
        chk({tag, "_done"}, 32'(ch_done), 1);
        chk({tag, "_hit"}, 32'(ch_hit), 32'(hit));
        chk({tag, "_path"}, 32'(path_sel), 32'(exp_ch));
        chk({tag, "_th"}, 32'(chip_th), 32'(exp_th));
        chk({tag, "_evt"}, 32'(evt_cnt), 32'(exp_evt));
        if (exp_period > 0 && last_done >= 0) chk({tag, "_period"}, 32'(cyc - last_done), 32'(exp_period));
        last_done = cyc;
    endtask

    task automatic stop_now(input string tag);
        bit tk;
        cfg_run = 1'b0;
        rstep(1'b0, 1'b0, tk);
        chk({tag, "_busy"}, 32'(sched_busy), 0);
        chk({tag, "_done"}, 32'(ch_done), 0);
        chk({tag, "_path"}, 32'(path_sel), 32'(exp_ch));
        chk({tag, "_th"}, 32'(chip_th), 32'(exp_th));
    endtask

    task automatic start(input logic [7:0] m);
        bit tk;
        cfg_ch_mask = m;
        cfg_run = 1'b1;
        rstep(1'b0, 1'b0, tk);
        exp_evt = 16'd0;
        chk("start_busy", 32'(sched_busy), 1);
        chk("start_evt", 32'(evt_cnt), 0);
        chk("start_merr", 32'(mask_err), 0);
        chk("start_path", 32'(path_sel), 32'(exp_ch));
    endtask

    // One channel visit starting with the FSM in SEL. stop_ph: 1 settle, 2 dwell, 3 hold, 4 capture.
    task automatic visit(input bit hit, input int hit_at, input int cap_len, input bit freeze, input int stop_ph);
        bit tk;
        bit frozen;
        int t;
        int dw;
        dw = (cfg_dwell == 16'd0) ? 1 : int'(cfg_dwell);
        exp_ch = next_ch(exp_ch, cfg_ch_mask);
        exp_th = cfg_th;
        rstep(1'b0, 1'b0, tk);
        mid_chk("sel");
        chk("sel_th", 32'(chip_th), 32'(exp_th));
        cfg_th = exp_th + 16'h0100;
        if (stop_ph == 1) begin
            stop_now("stop_settle");
            return;
        end
        t = 0;
        while (t < SETTLE) begin
            rstep(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), tk);
            if (tk) t++;
            mid_chk("settle");
        end
        if (stop_ph == 2) begin
            stop_now("stop_dwell");
            return;
        end
        t = 0;
        frozen = 1'b0;
        while (1) begin
            if (freeze && !frozen && t == dw - 1) begin
                frozen = 1'b1;
                repeat (20) begin
                    step(1'b1, 1'b0, 1'b1);
                    mid_chk("frozen");
                end
            end
            if (hit && t == hit_at - 1) begin
                step(1'b1, 1'b1, 1'b1);
                if (exp_evt != 16'hFFFF) exp_evt++;
                mid_chk("cap_entry");
                chk("cap_evt", 32'(evt_cnt), 32'(exp_evt));
                break;
            end
            rstep(1'b0, 1'($urandom_range(0, 1)), tk);
            if (tk) t++;
            if (!hit && t == dw) begin
                done_chk("dwell", 1'b0);
                return;
            end
            mid_chk("dwell");
        end
        if (stop_ph == 4) cfg_run = 1'b0;
        repeat (cap_len) begin
            rstep(1'b1, 1'b1, tk);
            mid_chk("capture");
        end
        tk = 1'b0;
        while (!tk) begin
            rstep(1'b0, 1'b0, tk);
            if (!tk) mid_chk("cap_wait");
        end
        if (stop_ph == 4) begin
            chk("capstop_done", 32'(ch_done), 1);
            chk("capstop_hit", 32'(ch_hit), 1);
            chk("capstop_busy", 32'(sched_busy), 0);
            chk("capstop_evt", 32'(evt_cnt), 32'(exp_evt));
            step(1'b1, 1'b1, 1'b0);
            chk("capstop_after_done", 32'(ch_done), 0);
            chk("capstop_after_busy", 32'(sched_busy), 0);
            return;
        end
        mid_chk("hold_entry");
        if (stop_ph == 3) begin
            stop_now("stop_hold");
            return;
        end
        if (cfg_holdoff == 16'd0) begin
            rstep(1'b0, 1'b0, tk);
            done_chk("hold0", 1'b1);
            return;
        end
        t = 0;
        while (1) begin
            rstep(1'b0, 1'b0, tk);
            if (tk) t++;
            if (t == int'(cfg_holdoff)) begin
                done_chk("hold", 1'b1);
                return;
            end
            mid_chk("hold");
        end
    endtask

    initial begin
        bit tk;
        bit h;
        int dwv;
        int ph;

        #12;
        chk("rst_path", 32'(path_sel), 0);
        chk("rst_th", 32'(chip_th), 0);
        chk("rst_busy", 32'(sched_busy), 0);
        chk("rst_done", 32'(ch_done), 0);
        chk("rst_hit", 32'(ch_hit), 0);
        chk("rst_evt", 32'(evt_cnt), 0);
        chk("rst_merr", 32'(mask_err), 0);
        @(negedge clk_sys);
        rst_n = 1'b1;

        // Two-channel scan with continuous ticks: visits 2,0,2,0 every 8 cycles; threshold latched per visit
        cont = 1'b1;
        exp_period = 8;
        last_done = -1;
        cfg_dwell = 16'd3;
        cfg_holdoff = 16'd0;
        cfg_th = 16'h0100;
        start(8'h05);
        repeat (4) visit(1'b0, 0, 0, 1'b0, 0);
        exp_period = 0;
        stop_now("stop_sel");

        // Single channel with a 5-tick capture window and holdoff 2
        cfg_holdoff = 16'd2;
        start(8'h80);
        visit(1'b1, 2, 4, 1'b0, 0);
        visit(1'b0, 0, 0, 1'b0, 0);
        stop_now("stop_sel2");

        // Empty mask at start
        cfg_ch_mask = 8'd0;
        cfg_run = 1'b1;
        rstep(1'b0, 1'b0, tk);
        chk("merr_set", 32'(mask_err), 1);
        chk("merr_busy", 32'(sched_busy), 0);
        rstep(1'b0, 1'b0, tk);
        chk("merr_busy2", 32'(sched_busy), 0);
        cfg_run = 1'b0;
        rstep(1'b0, 1'b0, tk);
        chk("merr_sticky", 32'(mask_err), 1);
        start(8'h01);
        visit(1'b0, 0, 0, 1'b0, 0);

        // Stalled downstream buffer during dwell, including capture at the final dwell tick
        cont = 1'b0;
        cfg_dwell = 16'd4;
        cfg_holdoff = 16'd1;
        cfg_ch_mask = 8'h42;
        visit(1'b0, 0, 0, 1'b1, 0);
        visit(1'b1, 4, 1, 1'b1, 0);

        // Stop in capture, then in each other phase
        visit(1'b1, 1, 3, 1'b0, 4);
        for (int p = 1; p <= 3; p++) begin
            start(8'h99);
            visit(1'b1, 2, 1, 1'b0, p);
        end

        // Mask cleared mid-scan
        start(8'h3C);
        visit(1'b0, 0, 0, 1'b0, 0);
        cfg_ch_mask = 8'd0;
        rstep(1'b0, 1'b0, tk);
        chk("midmask_merr", 32'(mask_err), 1);
        chk("midmask_busy", 32'(sched_busy), 0);
        chk("midmask_path", 32'(path_sel), 32'(exp_ch));
        cfg_run = 1'b0;
        rstep(1'b0, 1'b0, tk);

        // Randomized visits
        cfg_ch_mask = 8'hA5;
        start(cfg_ch_mask);
        for (int i = 0; i < 40; i++) begin
            cont = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) cfg_ch_mask = 8'($urandom_range(1, 255));
            dwv = $urandom_range(0, 5);
            cfg_dwell = 16'(dwv);
            cfg_holdoff = 16'($urandom_range(0, 3));
            h = 1'($urandom_range(0, 1));
            ph = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0;
            if (ph >= 3) h = 1'b1;
            visit(h, $urandom_range(1, (dwv == 0) ? 1 : dwv), $urandom_range(0, 4),
                  ($urandom_range(0, 5) == 0), ph);
            if (ph != 0) start(cfg_ch_mask);
        end

        // Asynchronous reset mid-scan
        rstep(1'b0, 1'b0, tk);
        rstep(1'b0, 1'b0, tk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_path", 32'(path_sel), 0);
        chk("arst_th", 32'(chip_th), 0);
        chk("arst_busy", 32'(sched_busy), 0);
        chk("arst_done", 32'(ch_done), 0);
        chk("arst_hit", 32'(ch_hit), 0);
        chk("arst_evt", 32'(evt_cnt), 0);
        chk("arst_merr", 32'(mask_err), 0);
        cfg_run = 1'b0;
        @(negedge clk_sys);
        rst_n = 1'b1;
        exp_ch = 3'd0;
        exp_th = 16'd0;
        exp_evt = 16'd0;
        rstep(1'b0, 1'b0, tk);
        chk("arst_idle", 32'(sched_busy), 0);

`ifdef CHIP_SCHED_TIMEOUT_EN
        cont = 1'b1;
        cfg_cap_max = 20'd10;
        cfg_dwell = 16'd5;
        cfg_holdoff = 16'd0;
        start(8'h01);
        chk("to_clear", 32'(cap_to), 0);
        exp_ch = next_ch(exp_ch, cfg_ch_mask);
        exp_th = cfg_th;
        rstep(1'b0, 1'b0, tk);
        repeat (SETTLE) rstep(1'b0, 1'b0, tk);
        step(1'b1, 1'b1, 1'b1);
        exp_evt++;
        repeat (9) begin
            step(1'b1, 1'b1, 1'b1);
            chk("to_pending", 32'(cap_to), 0);
        end
        step(1'b1, 1'b1, 1'b1);
        chk("to_set", 32'(cap_to), 1);
        chk("to_nodone", 32'(ch_done), 0);
        step(1'b1, 1'b1, 1'b0);
        done_chk("to_hold", 1'b1);
        cfg_run = 1'b0;
        rstep(1'b0, 1'b0, tk);
        chk("to_sticky", 32'(cap_to), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
